// File: rtl/fft_r22sdf_cmult_pkg.sv
// rtl/fft_r22sdf_cmult_pkg.sv - shared constants, sequencer states and width helpers for the twiddle multiplier
package fft_r22sdf_cmult_pkg;

    // Rounding modes applied after the Q1.(TW-1) rescale.
    localparam int ROUND_TRUNC = 0;   // floor
    localparam int ROUND_CONV  = 1;   // round half to even

    // Time-shared multiplier sequencer: one Karatsuba partial product per state.
    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_M_F  = 2'd1,
        SEQ_M_R  = 2'd2,
        SEQ_M_I  = 2'd3
    } seq_state_t;

    // Full-precision Karatsuba product width: (DW+1) x (TW+1) operands, no truncation.
    function automatic int cmult_prod_width(input int dw, input int tw);
        return dw + tw + 2;
    endfunction

endpackage

// File: rtl/fft_round_sat.sv
// rtl/fft_round_sat.sv - arithmetic right shift, floor/convergent rounding and saturation
//
// Ports:
//   in_i   signed full-precision value, IN_WIDTH bits
//   out_o  signed (in_i >>> SHIFT), rounded per ROUND_MODE, clamped to OUT_WIDTH bits
//   sat_o  1 when clamping changed the value
module fft_round_sat
    import fft_r22sdf_cmult_pkg::*;
#(
    parameter int IN_WIDTH   = 37,
    parameter int OUT_WIDTH  = 25,
    parameter int SHIFT      = 9,
    parameter int ROUND_MODE = ROUND_CONV
) (
    input  logic [IN_WIDTH-1:0]  in_i,
    output logic [OUT_WIDTH-1:0] out_o,
    output logic                 sat_o
);

    // One guard bit above the shifted value so the +1 of rounding cannot wrap.
    localparam int QW = IN_WIDTH - SHIFT + 1;

    logic [QW-1:0]    q;
    logic [QW-1:0]    r;
    logic [SHIFT-1:0] frac;
    logic [SHIFT-1:0] half;
    logic             round_up;
    logic             fits;

    assign q    = {in_i[IN_WIDTH-1], in_i[IN_WIDTH-1:SHIFT]};
    assign frac = in_i[SHIFT-1:0];
    assign half = {1'b1, {(SHIFT-1){1'b0}}};

    // Truncation of a two's complement value is already floor. Convergent rounding
    // bumps above half, and exactly-half only when the kept LSB is odd.
    always_comb begin
        round_up = 1'b0;
        if (ROUND_MODE == ROUND_CONV) begin
            round_up = (frac > half) || ((frac == half) && q[0]);
        end
    end

    assign r = q + {{(QW-1){1'b0}}, round_up};

    // Value fits when every bit from the guard down to the output sign bit agrees.
    assign fits = (r[QW-1:OUT_WIDTH-1] == {(QW-OUT_WIDTH+1){r[QW-1]}});

    always_comb begin
        sat_o = !fits;
        if (fits) begin
            out_o = r[OUT_WIDTH-1:0];
        end else if (r[QW-1]) begin
            out_o = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        end else begin
            out_o = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end
    end

endmodule

// File: rtl/mult_add.sv
// rtl/mult_add.sv - registered signed multiply-accumulate p = a*b +/- c (one DSP slice)
//
// Ports:
//   clk_i, rst_n  clock, asynchronous active-low reset
//   en_i          load p_o this cycle
//   sub_i         0: p = a*b + c, 1: p = a*b - c
//   a_i, b_i      signed operands
//   c_i           signed addend, full product width
//   p_o           registered signed result, A_WIDTH+B_WIDTH bits
module mult_add #(
    parameter int A_WIDTH = 26,
    parameter int B_WIDTH = 11
) (
    input  logic                       clk_i,
    input  logic                       rst_n,
    input  logic                       en_i,
    input  logic                       sub_i,
    input  logic [A_WIDTH-1:0]         a_i,
    input  logic [B_WIDTH-1:0]         b_i,
    input  logic [A_WIDTH+B_WIDTH-1:0] c_i,
    output logic [A_WIDTH+B_WIDTH-1:0] p_o
);

    localparam int P_WIDTH = A_WIDTH + B_WIDTH;

    logic [P_WIDTH-1:0] prod;

    // Both operands sign-extended to the full width so the product is exact.
    assign prod = P_WIDTH'($signed(a_i)) * P_WIDTH'($signed(b_i));

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            p_o <= '0;
        end else if (en_i) begin
            p_o <= sub_i ? (prod - c_i) : (prod + c_i);
        end
    end

endmodule

// File: rtl/fft_r22sdf_cmult.sv
// rtl/fft_r22sdf_cmult.sv - R22SDF complex twiddle multiplier z = x*w, Karatsuba with 3 or 1 DSPs
//
// Ports:
//   clk_i, rst_n           clock, asynchronous active-low reset
//   valid_i / ready_o      input handshake (sample taken when both high)
//   ctr_i / ctr_o          FFT sample index, delayed exactly with the data
//   x_re_i, x_im_i         signed data, DATA_WIDTH
//   w_re_i, w_im_i         signed twiddle Q1.(TWIDDLE_WIDTH-1)
//   clr_ovf_i              clears the sticky overflow flag
//   valid_o                one-cycle strobe per accepted sample
//   z_re_o, z_im_o         rounded, saturated product
//   ovf_o                  sticky saturation flag
module fft_r22sdf_cmult
    import fft_r22sdf_cmult_pkg::*;
#(
    parameter int DATA_WIDTH    = 25,
    parameter int TWIDDLE_WIDTH = 10,
    parameter int NLOG2         = 10,
    parameter int NUM_MULTS     = 3,
    parameter int ROUND_MODE    = ROUND_CONV
) (
    input  logic                     clk_i,
    input  logic                     rst_n,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [NLOG2-1:0]         ctr_i,
    input  logic [DATA_WIDTH-1:0]    x_re_i,
    input  logic [DATA_WIDTH-1:0]    x_im_i,
    input  logic [TWIDDLE_WIDTH-1:0] w_re_i,
    input  logic [TWIDDLE_WIDTH-1:0] w_im_i,
    input  logic                     clr_ovf_i,
    output logic                     valid_o,
    output logic [NLOG2-1:0]         ctr_o,
    output logic [DATA_WIDTH-1:0]    z_re_o,
    output logic [DATA_WIDTH-1:0]    z_im_o,
    output logic                     ovf_o
);

    localparam int AW = DATA_WIDTH + 1;
    localparam int BW = TWIDDLE_WIDTH + 1;
    localparam int PW = cmult_prod_width(DATA_WIDTH, TWIDDLE_WIDTH);

    // Operands sign-extended by one bit so differences and sums are exact.
    logic [AW-1:0] xr_ext, xi_ext, e_in;
    logic [BW-1:0] wr_ext, wi_ext, dw_in, sw_in;

    assign xr_ext = {x_re_i[DATA_WIDTH-1], x_re_i};
    assign xi_ext = {x_im_i[DATA_WIDTH-1], x_im_i};
    assign wr_ext = {w_re_i[TWIDDLE_WIDTH-1], w_re_i};
    assign wi_ext = {w_im_i[TWIDDLE_WIDTH-1], w_im_i};
    assign e_in   = xr_ext - xi_ext;
    assign dw_in  = wr_ext - wi_ext;
    assign sw_in  = wr_ext + wi_ext;

    // Full-precision result handed to the common round/saturate output stage.
    logic             res_valid;
    logic [NLOG2-1:0] res_ctr;
    logic [PW-1:0]    res_re, res_im;

    if (NUM_MULTS == 3) begin : g_full
        // Stage 1: operand prep. Stage 2: f = w_re*e. Stage 3: R and I in parallel.
        logic [AW-1:0]    s1_xr, s1_xi, s1_e, s2_xr, s2_xi;
        logic [BW-1:0]    s1_wr, s1_dw, s1_sw, s2_dw, s2_sw;
        logic [PW-1:0]    s2_f;
        logic [2:0]       vld;
        logic [NLOG2-1:0] ctr_s1, ctr_s2, ctr_s3;

        always_ff @(posedge clk_i or negedge rst_n) begin
            if (!rst_n) begin
                vld    <= '0;
                ctr_s1 <= '0;
                ctr_s2 <= '0;
                ctr_s3 <= '0;
                s1_xr  <= '0;
                s1_xi  <= '0;
                s1_e   <= '0;
                s1_wr  <= '0;
                s1_dw  <= '0;
                s1_sw  <= '0;
                s2_xr  <= '0;
                s2_xi  <= '0;
                s2_dw  <= '0;
                s2_sw  <= '0;
            end else begin
                vld    <= {vld[1:0], valid_i};
                ctr_s1 <= ctr_i;
                ctr_s2 <= ctr_s1;
                ctr_s3 <= ctr_s2;
                s1_xr  <= xr_ext;
                s1_xi  <= xi_ext;
                s1_e   <= e_in;
                s1_wr  <= wr_ext;
                s1_dw  <= dw_in;
                s1_sw  <= sw_in;
                s2_xr  <= s1_xr;
                s2_xi  <= s1_xi;
                s2_dw  <= s1_dw;
                s2_sw  <= s1_sw;
            end
        end

        mult_add #(.A_WIDTH(AW), .B_WIDTH(BW)) u_mult_f (
            .clk_i (clk_i), .rst_n (rst_n), .en_i (1'b1), .sub_i (1'b0),
            .a_i (s1_e), .b_i (s1_wr), .c_i ('0), .p_o (s2_f)
        );

        mult_add #(.A_WIDTH(AW), .B_WIDTH(BW)) u_mult_r (
            .clk_i (clk_i), .rst_n (rst_n), .en_i (1'b1), .sub_i (1'b0),
            .a_i (s2_xi), .b_i (s2_dw), .c_i (s2_f), .p_o (res_re)
        );

        mult_add #(.A_WIDTH(AW), .B_WIDTH(BW)) u_mult_i (
            .clk_i (clk_i), .rst_n (rst_n), .en_i (1'b1), .sub_i (1'b1),
            .a_i (s2_xr), .b_i (s2_sw), .c_i (s2_f), .p_o (res_im)
        );

        assign ready_o   = 1'b1;
        assign res_valid = vld[2];
        assign res_ctr   = ctr_s3;
    end else begin : g_shared
        seq_state_t       state_q, state_d;
        logic             rdy, accept;
        logic [AW-1:0]    h_xr, h_xi, h_e, ma;
        logic [BW-1:0]    h_wr, h_dw, h_sw, mb;
        logic [PW-1:0]    mc, p, f_hold, r_hold;
        logic             msub, men;
        logic [NLOG2-1:0] h_ctr, res_ctr_q;
        logic             res_vld_q;

        always_ff @(posedge clk_i or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= SEQ_IDLE;
            end else begin
                state_q <= state_d;
            end
        end

        // Sequencer and the operand mux for the single DSP.
        always_comb begin
            state_d = state_q;
            rdy     = 1'b0;
            ma      = '0;
            mb      = '0;
            mc      = '0;
            msub    = 1'b0;
            case (state_q)
                SEQ_IDLE: begin
                    rdy = 1'b1;
                    if (valid_i) state_d = SEQ_M_F;
                end
                SEQ_M_F: begin
                    ma      = h_e;
                    mb      = h_wr;
                    state_d = SEQ_M_R;
                end
                SEQ_M_R: begin
                    ma      = h_xi;
                    mb      = h_dw;
                    mc      = p;        // f, produced last cycle
                    state_d = SEQ_M_I;
                end
                SEQ_M_I: begin
                    ma      = h_xr;
                    mb      = h_sw;
                    mc      = f_hold;
                    msub    = 1'b1;
                    rdy     = 1'b1;
                    state_d = valid_i ? SEQ_M_F : SEQ_IDLE;
                end
                default: state_d = SEQ_IDLE;
            endcase
        end

        assign accept  = valid_i && rdy;
        assign men     = (state_q != SEQ_IDLE);
        assign ready_o = rdy;

        // A new sample may be loaded in M_I: the I product reads the holding
        // registers combinationally in that same cycle, before they change.
        always_ff @(posedge clk_i or negedge rst_n) begin
            if (!rst_n) begin
                h_xr      <= '0;
                h_xi      <= '0;
                h_e       <= '0;
                h_wr      <= '0;
                h_dw      <= '0;
                h_sw      <= '0;
                h_ctr     <= '0;
                f_hold    <= '0;
                r_hold    <= '0;
                res_vld_q <= 1'b0;
                res_ctr_q <= '0;
            end else begin
                if (accept) begin
                    h_xr  <= xr_ext;
                    h_xi  <= xi_ext;
                    h_e   <= e_in;
                    h_wr  <= wr_ext;
                    h_dw  <= dw_in;
                    h_sw  <= sw_in;
                    h_ctr <= ctr_i;
                end
                if (state_q == SEQ_M_R) f_hold <= p;
                if (state_q == SEQ_M_I) begin
                    r_hold    <= p;
                    res_ctr_q <= h_ctr;
                end
                res_vld_q <= (state_q == SEQ_M_I);
            end
        end

        mult_add #(.A_WIDTH(AW), .B_WIDTH(BW)) u_mult (
            .clk_i (clk_i), .rst_n (rst_n), .en_i (men), .sub_i (msub),
            .a_i (ma), .b_i (mb), .c_i (mc), .p_o (p)
        );

        // I stays in the DSP register for the cycle after M_I, R was parked in r_hold.
        assign res_valid = res_vld_q;
        assign res_ctr   = res_ctr_q;
        assign res_re    = r_hold;
        assign res_im    = p;
    end

    logic [DATA_WIDTH-1:0] rs_re, rs_im;
    logic                  sat_re, sat_im;

    fft_round_sat #(
        .IN_WIDTH (PW), .OUT_WIDTH (DATA_WIDTH),
        .SHIFT (TWIDDLE_WIDTH - 1), .ROUND_MODE (ROUND_MODE)
    ) u_rs_re (
        .in_i (res_re), .out_o (rs_re), .sat_o (sat_re)
    );

    fft_round_sat #(
        .IN_WIDTH (PW), .OUT_WIDTH (DATA_WIDTH),
        .SHIFT (TWIDDLE_WIDTH - 1), .ROUND_MODE (ROUND_MODE)
    ) u_rs_im (
        .in_i (res_im), .out_o (rs_im), .sat_o (sat_im)
    );

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            valid_o <= 1'b0;
            ctr_o   <= '0;
            z_re_o  <= '0;
            z_im_o  <= '0;
            ovf_o   <= 1'b0;
        end else begin
            valid_o <= res_valid;
            if (res_valid) begin
                ctr_o  <= res_ctr;
                z_re_o <= rs_re;
                z_im_o <= rs_im;
            end
            // A fresh saturation wins over a simultaneous clear.
            if (res_valid && (sat_re || sat_im)) begin
                ovf_o <= 1'b1;
            end else if (clr_ovf_i) begin
                ovf_o <= 1'b0;
            end
        end
    end

endmodule
